// File: rtl/fifo_mem_array_mc.sv
// Multi-channel FIFO: NUM_CH independent queues share one storage array,
// channel c owning entries c*DEPTH .. c*DEPTH+DEPTH-1, with one registered read port.
module fifo_mem_array_mc #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_CH          = 4,
  parameter int DEPTH           = 8,
  parameter int THRESHOLD_VALUE = DEPTH / 2,
  parameter int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W           = $clog2(DEPTH + 1)
) (
  input  logic                      clk_in,
  input  logic                      areset,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic [NUM_CH-1:0]         full,
  output logic [NUM_CH-1:0]         empty,
  output logic [NUM_CH-1:0]         almost_full,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic [NUM_CH-1:0]         overflow_err,
  output logic [NUM_CH-1:0]         underflow_err,
  input  logic                      err_clr
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ADDR_W = (NUM_CH * DEPTH > 1) ? $clog2(NUM_CH * DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [NUM_CH*DEPTH];
  logic [PTR_W-1:0]      r_wptr [NUM_CH];
  logic [PTR_W-1:0]      r_rptr [NUM_CH];
  logic [CNT_W-1:0]      r_cnt [NUM_CH];
  logic [CNT_W-1:0]      w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]     r_full, r_empty, r_afull, r_ovf, r_unf;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic              w_wr_req, w_rd_req, w_wr_acc, w_rd_acc;
  logic [ADDR_W-1:0] w_waddr, w_raddr;
  logic [NUM_CH-1:0] w_wr_hit, w_rd_hit, w_ovf_set, w_unf_set;

  function automatic logic ch_valid(input logic [CH_W-1:0] ch);
    return (32'(ch) < 32'(NUM_CH));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Request decode; full/empty come from pre-edge registered state, no bypass.
  always_comb begin
    w_wr_req  = wr_en & ch_valid(wr_ch);
    w_rd_req  = rd_en & ch_valid(rd_ch);
    w_wr_acc  = 1'b0;
    w_rd_acc  = 1'b0;
    w_waddr   = {ADDR_W{1'b0}};
    w_raddr   = {ADDR_W{1'b0}};
    w_wr_hit  = {NUM_CH{1'b0}};
    w_rd_hit  = {NUM_CH{1'b0}};
    w_ovf_set = {NUM_CH{1'b0}};
    w_unf_set = {NUM_CH{1'b0}};
    if (w_wr_req) begin
      w_wr_acc = ~r_full[wr_ch];
      w_waddr  = ADDR_W'(wr_ch) * ADDR_W'(DEPTH) + ADDR_W'(r_wptr[wr_ch]);
    end else begin
      w_wr_acc = 1'b0;
    end
    if (w_rd_req) begin
      w_rd_acc = ~r_empty[rd_ch];
      w_raddr  = ADDR_W'(rd_ch) * ADDR_W'(DEPTH) + ADDR_W'(r_rptr[rd_ch]);
    end else begin
      w_rd_acc = 1'b0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      w_wr_hit[k]  = w_wr_req && (wr_ch == CH_W'(k)) && w_wr_acc;
      w_rd_hit[k]  = w_rd_req && (rd_ch == CH_W'(k)) && w_rd_acc;
      w_ovf_set[k] = w_wr_req && (wr_ch == CH_W'(k)) && !w_wr_acc;
      w_unf_set[k] = w_rd_req && (rd_ch == CH_W'(k)) && !w_rd_acc;
    end
  end

  // Next occupancy per channel.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_cnt_nxt[k] = r_cnt[k] + CNT_W'(w_wr_hit[k]) - CNT_W'(w_rd_hit[k]);
    end
  end

  // Per-channel pointers, counters, status flags and sticky errors.
  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k] <= {PTR_W{1'b0}};
        r_rptr[k] <= {PTR_W{1'b0}};
        r_cnt[k]  <= {CNT_W{1'b0}};
      end
      r_full  <= {NUM_CH{1'b0}};
      r_empty <= {NUM_CH{1'b1}};
      r_afull <= {NUM_CH{1'b0}};
      r_ovf   <= {NUM_CH{1'b0}};
      r_unf   <= {NUM_CH{1'b0}};
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_wr_hit[k]) begin
          r_wptr[k] <= ptr_inc(r_wptr[k]);
        end
        if (w_rd_hit[k]) begin
          r_rptr[k] <= ptr_inc(r_rptr[k]);
        end
        r_cnt[k]   <= w_cnt_nxt[k];
        r_full[k]  <= (w_cnt_nxt[k] == CNT_W'(DEPTH));
        r_empty[k] <= (w_cnt_nxt[k] == {CNT_W{1'b0}});
        r_afull[k] <= (w_cnt_nxt[k] >= CNT_W'(THRESHOLD_VALUE));
        // A set event in the same cycle as err_clr wins.
        r_ovf[k]   <= w_ovf_set[k] | (r_ovf[k] & ~err_clr);
        r_unf[k]   <= w_unf_set[k] | (r_unf[k] & ~err_clr);
      end
    end
  end

  // Shared storage; intentionally not reset.
  always_ff @(posedge clk_in) begin
    if (w_wr_acc) begin
      r_mem[w_waddr] <= wr_data;
    end
  end

  // Registered read port: one-cycle valid pulse, data holds otherwise.
  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      r_rd_data  <= {DATA_WIDTH{1'b0}};
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[w_raddr];
      end
    end
  end

  // Flatten per-channel counters onto the count bus.
  always_comb begin
    count = {(NUM_CH*CNT_W){1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      count[k*CNT_W +: CNT_W] = r_cnt[k];
    end
  end

  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign full          = r_full;
  assign empty         = r_empty;
  assign almost_full   = r_afull;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: tb/tb_fifo_mem_array_mc.sv
// Scoreboard bench for fifo_mem_array_mc: reads push expected words with their
// due cycle; a negedge monitor pops and compares whenever rd_valid is seen.
module tb_fifo_mem_array_mc;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int DEP = 8;
  localparam int CHW = 2;
  localparam int CW  = 4;

  logic              clk_in = 1'b0;
  logic              areset = 1'b1;
  logic              wr_en = 1'b0;
  logic [CHW-1:0]    wr_ch = 2'd0;
  logic [DW-1:0]     wr_data = 32'd0;
  logic              rd_en = 1'b0;
  logic [CHW-1:0]    rd_ch = 2'd0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic [NCH-1:0]    full, empty, almost_full, overflow_err, underflow_err;
  logic [NCH*CW-1:0] count;
  logic              err_clr = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  fifo_mem_array_mc #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .THRESHOLD_VALUE(DEP/2)
  ) dut (
    .clk_in(clk_in), .areset(areset),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .err_clr(err_clr)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every rd_valid pulse must match the oldest expected word and its due cycle.
  always @(negedge clk_in) begin
    if (!areset && rd_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 rd_data=%h at cycle %0d, required no pending read",
                 rd_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (rd_data !== mon_e.data || cyc != mon_e.cyc) begin
          n_errors++;
          $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d",
                   rd_data, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    return 32'(count[k*CW +: CW]);
  endfunction

  // One clock of stimulus; push=1 registers an expected read word due next cycle.
  task automatic step(input logic we, input logic [CHW-1:0] wc, input logic [DW-1:0] wd,
                      input logic re, input logic [CHW-1:0] rc,
                      input logic push, input logic [DW-1:0] ed);
    exp_t e;
    wr_en = we; wr_ch = wc; wr_data = wd;
    rd_en = re; rd_ch = rc;
    if (push) begin
      e.data = ed;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk_in);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr(input logic [CHW-1:0] c, input logic [DW-1:0] d);
    step(1'b1, c, d, 1'b0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [CHW-1:0] c, input logic [DW-1:0] d);
    step(1'b0, 2'd0, 32'd0, 1'b1, c, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
  endtask

  initial begin
    // Reset and idle.
    repeat (3) @(posedge clk_in);
    #1 areset = 1'b0;
    idle();
    chk("reset_empty", 32'(empty), 32'h0000000F);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_errs", 32'({overflow_err, underflow_err}), 32'h0);

    // Fill channel 1, watch almost_full/full, then overflow.
    for (int i = 0; i < 8; i++) begin
      wr(2'd1, 32'hA0 + 32'(i));
      chk("ch1_count", cnt_of(1), 32'(i + 1));
      chk("ch1_afull", 32'(almost_full[1]), (i + 1 >= 4) ? 32'd1 : 32'd0);
      chk("ch1_full", 32'(full[1]), (i + 1 == 8) ? 32'd1 : 32'd0);
    end
    wr(2'd1, 32'hFF);
    chk("ch1_ovf", 32'(overflow_err), 32'h2);
    chk("ch1_count_full", cnt_of(1), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd(2'd1, 32'hA0 + 32'(i));
    end
    idle();
    chk("ch1_rd_valid_pulse", 32'(rd_valid), 32'h0);
    chk("ch1_rd_data_hold", rd_data, 32'hA7);
    chk("ch1_drained", cnt_of(1), 32'd0);
    chk("ch1_empty", 32'(empty[1]), 32'd1);
    step(1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0, 32'd0);
    chk("ch1_unf", 32'(underflow_err), 32'h2);
    chk("ch1_ovf_sticky", 32'(overflow_err), 32'h2);
    chk("ch1_refused_hold", rd_data, 32'hA7);
    err_clr = 1'b1;
    idle();
    chk("clr_errs", 32'({overflow_err, underflow_err}), 32'h0);

    // Interleave channels 0 and 3, including a cross-channel write+read.
    wr(2'd0, 32'h10);
    wr(2'd3, 32'h30);
    wr(2'd0, 32'h11);
    wr(2'd3, 32'h31);
    chk("il_cnt0", cnt_of(0), 32'd2);
    chk("il_cnt3", cnt_of(3), 32'd2);
    step(1'b1, 2'd0, 32'h12, 1'b1, 2'd3, 1'b1, 32'h30);
    chk("il_cnt0_b", cnt_of(0), 32'd3);
    chk("il_cnt3_b", cnt_of(3), 32'd1);
    rd(2'd0, 32'h10);
    rd(2'd3, 32'h31);
    rd(2'd0, 32'h11);
    rd(2'd0, 32'h12);
    chk("il_count_zero", 32'(count), 32'h0);
    chk("il_empty", 32'(empty), 32'h0000000F);

    // Pointer wrap on channel 2.
    for (int i = 0; i < 6; i++) wr(2'd2, 32'h20 + 32'(i));
    for (int i = 0; i < 6; i++) rd(2'd2, 32'h20 + 32'(i));
    for (int i = 0; i < 5; i++) wr(2'd2, 32'h40 + 32'(i));
    chk("wrap_cnt2", cnt_of(2), 32'd5);
    for (int i = 0; i < 5; i++) rd(2'd2, 32'h40 + 32'(i));
    chk("wrap_cnt2_end", cnt_of(2), 32'd0);

    // Same-channel read+write on empty, then on full channel 0.
    step(1'b1, 2'd0, 32'h50, 1'b1, 2'd0, 1'b0, 32'd0);
    chk("sim_empty_unf", 32'(underflow_err), 32'h1);
    chk("sim_empty_cnt", cnt_of(0), 32'd1);
    for (int i = 1; i < 8; i++) wr(2'd0, 32'h50 + 32'(i));
    chk("sim_full_flag", 32'(full[0]), 32'd1);
    step(1'b1, 2'd0, 32'h99, 1'b1, 2'd0, 1'b1, 32'h50);
    chk("sim_full_ovf", 32'(overflow_err), 32'h1);
    chk("sim_full_cnt", cnt_of(0), 32'd7);
    chk("sim_full_deassert", 32'(full[0]), 32'd0);
    err_clr = 1'b1;
    idle();
    chk("sim_clr", 32'({overflow_err, underflow_err}), 32'h0);

    // Reset in the middle of a read request.
    rd_en = 1'b1; rd_ch = 2'd0;
    #3 areset = 1'b1;
    @(posedge clk_in);
    #2 areset = 1'b0; rd_en = 1'b0;
    @(posedge clk_in);
    #1;
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_empty", 32'(empty), 32'h0000000F);
    chk("mid_rst_rd_data", rd_data, 32'h0);
    step(1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b0, 32'd0);
    chk("post_rst_unf", 32'(underflow_err), 32'h1);
    chk("post_rst_no_valid", 32'(rd_valid), 32'h0);

    // Every expected read must have been observed.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_mem_array_mc.md
Name: fifo_mem_array_mc

Overview:
Multi-channel FIFO storage block and the successor of the single-queue memory array. NUM_CH independent FIFOs share one storage array, with each channel owning a fixed region of DEPTH entries. Per-channel pointers, occupancy counters, status flags and sticky error flags are kept internally. It sits between a channel-tagged producer and consumer in the FIFO memory subsystem, with one write port and one registered read port.

Parameters:
DATA_WIDTH, 32, width of each stored word
NUM_CH, 4, number of independent channels (>=1)
DEPTH, 8, entries per channel (>=2; need not be a power of two)
THRESHOLD_VALUE, DEPTH/2, occupancy at or above which almost_full asserts (1..DEPTH)
CH_W, (NUM_CH>1)?$clog2(NUM_CH):1, channel select width (derived)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk_in  input  1  clock; all logic on the rising edge
areset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_ch  input  CH_W  target channel of the write
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_ch  input  CH_W  source channel of the read
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  rd_data holds a newly popped word this cycle
full  output  NUM_CH  per-channel count==DEPTH
empty  output  NUM_CH  per-channel count==0
almost_full  output  NUM_CH  per-channel count>=THRESHOLD_VALUE
count  output  NUM_CH*CNT_W  per-channel occupancy; channel k in bits [k*CNT_W +: CNT_W]
overflow_err  output  NUM_CH  sticky: a write was dropped on a full channel
underflow_err  output  NUM_CH  sticky: a read was refused on an empty channel
err_clr  input  1  synchronous pulse that clears all sticky error bits

Behaviour:
- Reset (areset high, asynchronous, any time):
  - Pointers and counts go to 0 and empty goes to all-ones.
  - full, almost_full, rd_valid and rd_data go to 0. Error flags go to 0.
  - Storage contents are not reset and are don't-care until written.
  - A read in flight at reset is squashed: rd_valid is not asserted after reset releases.
- Address mapping: channel c, pointer p -> storage index c*DEPTH+p.
- Write: wr_en=1 and full[wr_ch]=0 at the clock edge:
  - store wr_data at the channel's write pointer;
  - advance the write pointer, wrapping DEPTH-1 -> 0.
- Dropped write: wr_en=1 and full[wr_ch]=1:
  - data is discarded and no state changes;
  - overflow_err[wr_ch] sets next cycle.
- Read: rd_en=1 and empty[rd_ch]=0 at edge N:
  - rd_data = word at the read pointer and rd_valid=1 in cycle N+1 (latency 1);
  - the read pointer advances, wrapping DEPTH-1 -> 0.
- Refused read: rd_en=1 and empty[rd_ch]=1:
  - rd_valid=0 next cycle and rd_data holds its previous value;
  - underflow_err[rd_ch] sets.
- rd_valid is a single-cycle pulse per accepted read. rd_data holds its value when rd_valid=0.
- Flag evaluation: full and empty are evaluated on the state before the edge, with no same-cycle bypass.
  - Same channel, empty, simultaneous read and write: the write is stored, the read is refused (underflow), and the count becomes 1.
  - Same channel, full, simultaneous read and write: the read is accepted, the write is dropped (overflow), and the count becomes DEPTH-1.
  - Same channel, neither full nor empty: both are accepted and the count is unchanged.
- Different channels: the write and read proceed independently in the same cycle.
- Count update: count += write_accepted - read_accepted. The count never exceeds DEPTH and never goes below 0.
- Status outputs (full, empty, almost_full, count) are registered and reflect the post-edge state in the cycle after the update.
- Errors: sticky until err_clr=1. If a set event and err_clr occur in the same cycle, the set wins.
- Channel select out of range (wr_ch or rd_ch >= NUM_CH): the request is ignored and no flags change.

Test Plan:
- Reset then idle -> empty=all-ones, full=0, count=0, rd_valid=0, rd_data=0.
- DEPTH=8, ch1: write 0xA0..0xA7 -> full[1]=1, almost_full[1]=1 from count 4; a ninth write of 0xFF sets overflow_err[1] and count stays 8. Read 8 times -> rd_data 0xA0..0xA7, one cycle after each rd_en.
- Interleave ch0 and ch3 (writes 0x10/0x30, reads in alternating order) -> per-channel order is preserved with no cross-channel corruption, and the channels' counts are independent.
- Wrap: on ch2 write 6, read 6, then write 5, read 5 -> pointers wrap past 7 and the data order is intact.
- Simultaneous same-channel read+write on empty ch0 -> underflow_err[0]=1, count=1. On full ch0 -> overflow_err[0]=1, count=7, and rd_data is the oldest word. Then err_clr -> both flags clear.
- Assert areset mid-read (rd_en high) -> rd_valid stays 0, all counts 0, and the previously written data is unreachable.
